// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: buffers a tile of A vectors and replays them diagonally skewed into the MAC array (optional stall via FEEDER_STALL_EN)
module systolic_skew_feeder #(
  parameter int WORD_SIZE = 16,
  parameter int ROWS      = 4,
  parameter int DEPTH     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS*WORD_SIZE-1:0]    in_data,
  input  logic                         in_last,
  output logic [ROWS*WORD_SIZE-1:0]    left_out,
  output logic                         out_valid,
  output logic                         mac_en,
  output logic                         tile_done,
  output logic [$clog2(DEPTH+1)-1:0]   k_count
`ifdef FEEDER_STALL_EN
  ,
  input  logic                         stall
`endif
);
  localparam int KW = $clog2(DEPTH+1);
  localparam int TW = $clog2(DEPTH+ROWS);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;
  state_t state_q, state_d;
  logic [ROWS*WORD_SIZE-1:0] mem [DEPTH];
  logic [ROWS*WORD_SIZE-1:0] skew;
  logic [TW-1:0] t;
  logic xfer, hold, last_step, ov_q;
`ifdef FEEDER_STALL_EN
  assign hold = stall && state_q == STREAM;
`else
  assign hold = 1'b0;
`endif
  assign in_ready  = !rst && (state_q == IDLE || state_q == LOAD);
  assign xfer      = in_valid && in_ready;
  assign last_step = {1'b0, t} == (TW+1)'(k_count) + (TW+1)'(ROWS-2);
  assign out_valid = ov_q && !hold;
  assign mac_en    = out_valid;
  // lane g replays vector t-g while that index lies inside the tile
  for (genvar g = 0; g < ROWS; g++) begin : lane
    logic [TW:0] d;
    assign d = {1'b0, t} - (TW+1)'(g);
    assign skew[g*WORD_SIZE +: WORD_SIZE] =
      ({1'b0, t} >= (TW+1)'(g) && d < (TW+1)'(k_count)) ? mem[d[AW-1:0]][g*WORD_SIZE +: WORD_SIZE] : '0;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (xfer) state_d = in_last ? STREAM : LOAD;
      LOAD:   if (xfer && (in_last || k_count == KW'(DEPTH-1))) state_d = STREAM;
      STREAM: if (!hold && last_step) state_d = DONE;
      DONE:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (xfer) mem[state_q == IDLE ? AW'(0) : k_count[AW-1:0]] <= in_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      t         <= '0;
      k_count   <= '0;
      left_out  <= '0;
      ov_q      <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      tile_done <= state_q == DONE;
      if (xfer) k_count <= state_q == IDLE ? KW'(1) : k_count + 1'b1;
      if (state_q == STREAM && !hold) begin
        left_out <= skew;
        ov_q     <= 1'b1;
        t        <= last_step ? '0 : t + 1'b1;
      end
      if (state_q == DONE) begin
        left_out <= '0;
        ov_q     <= 1'b0;
      end
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: directed self-checking bench for systolic_skew_feeder
module tb_systolic_skew_feeder;
  localparam int W = 16, R = 4, D = 16;
  logic clk = 1'b0, rst, in_valid, in_last, in_ready, out_valid, mac_en, tile_done;
  logic [R*W-1:0] in_data, left_out;
  logic [4:0] k_count;
`ifdef FEEDER_STALL_EN
  logic stall = 1'b0;
`endif
  int ntests = 0, nfail = 0;
  systolic_skew_feeder #(.WORD_SIZE(W), .ROWS(R), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .left_out(left_out), .out_valid(out_valid), .mac_en(mac_en),
    .tile_done(tile_done), .k_count(k_count)
`ifdef FEEDER_STALL_EN
    , .stall(stall)
`endif
  );
  always #5 clk = ~clk;
  task automatic send(input logic [R*W-1:0] d, input logic l);
    int i = 0;
    while (!in_ready && i < 50) begin @(negedge clk); i++; end
    ntests++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL send_wait in_ready=%b exp=1", in_ready); end
    in_valid = 1'b1; in_data = d; in_last = l;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    #1;
    ntests++; if ({in_ready, out_valid, mac_en, tile_done, k_count, left_out} !== '0) begin nfail++; $display("FAIL reset_outputs got=%h exp=0", {in_ready, out_valid, mac_en, tile_done, k_count, left_out}); end
    @(negedge clk); @(negedge clk); rst = 1'b0; @(negedge clk);
    ntests++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
  endtask
  task automatic test_reset_mid;
    send(64'h0004_0003_0002_0001, 1'b0);
    send(64'h0008_0007_0006_0005, 1'b0);
    send(64'h000C_000B_000A_0009, 1'b1);
    repeat (3) @(negedge clk);
    ntests++; if (left_out !== 64'h0000_0003_0006_0009) begin nfail++; $display("FAIL mid_step2 got=%h exp=%h", left_out, 64'h0000_0003_0006_0009); end
    rst = 1'b1; #1;
    ntests++; if ({in_ready, out_valid, mac_en, tile_done, k_count, left_out} !== '0) begin nfail++; $display("FAIL mid_reset_outputs got=%h exp=0", {in_ready, out_valid, mac_en, tile_done, k_count, left_out}); end
    @(negedge clk); rst = 1'b0; #1;
    ntests++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL mid_reset_ready got=%b exp=1", in_ready); end
    @(negedge clk);
  endtask
  task automatic test_basic;
    logic [R*W-1:0] exp [6] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0002_0005, 64'h0000_0003_0006_0009,
                                64'h0004_0007_000A_0000, 64'h0008_000B_0000_0000, 64'h000C_0000_0000_0000};
    send(64'h0004_0003_0002_0001, 1'b0);
    send(64'h0008_0007_0006_0005, 1'b0);
    send(64'h000C_000B_000A_0009, 1'b1);
    ntests++; if ({in_ready, out_valid, k_count} !== {2'b00, 5'd3}) begin nfail++; $display("FAIL basic_e0 got=%b exp=%b", {in_ready, out_valid, k_count}, {2'b00, 5'd3}); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ntests++; if ({out_valid, mac_en, tile_done, left_out} !== {3'b110, exp[c]}) begin nfail++; $display("FAIL basic_step%0d got=%b/%h exp=110/%h", c, {out_valid, mac_en, tile_done}, left_out, exp[c]); end
    end
    @(negedge clk);
    ntests++; if ({out_valid, mac_en, tile_done, k_count, left_out} !== {3'b001, 5'd3, 64'h0}) begin nfail++; $display("FAIL basic_done got=%b k=%0d lo=%h exp=001 k=3 lo=0", {out_valid, mac_en, tile_done}, k_count, left_out); end
    @(negedge clk);
    ntests++; if ({tile_done, in_ready} !== 2'b01) begin nfail++; $display("FAIL basic_after got=%b exp=01", {tile_done, in_ready}); end
  endtask
  task automatic test_k1;
    logic [R*W-1:0] v = 64'hDDDD_CCCC_BBBB_AAAA, m;
    int nv = 0;
    send(v, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      nv += int'(out_valid);
      m = c < 4 ? v & (64'hFFFF << (16*c)) : 64'h0;
      ntests++; if (left_out !== m || tile_done !== (c == 4)) begin nfail++; $display("FAIL k1_cycle%0d got=%h td=%b exp=%h td=%b", c, left_out, tile_done, m, c == 4); end
    end
    ntests++; if (nv != 4) begin nfail++; $display("FAIL k1_valid_cycles got=%0d exp=4", nv); end
  endtask
  task automatic test_back_to_back;
    logic [R*W-1:0] d, x = 64'h4444_3333_2222_1111;
    int nv = 0, j;
    for (int v = 0; v < D; v++) begin
      for (int r = 0; r < R; r++) d[r*W +: W] = 16'(16'h1000 + 256*v + r);
      send(d, 1'b0);
    end
    in_valid = 1'b1; in_data = x; in_last = 1'b1;
    ntests++; if ({in_ready, k_count} !== {1'b0, 5'd16}) begin nfail++; $display("FAIL forced_close got=%b exp=%b", {in_ready, k_count}, {1'b0, 5'd16}); end
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      nv += int'(out_valid);
      for (int r = 0; r < R; r++) begin
        j = c - r;
        d[r*W +: W] = (j >= 0 && j < D) ? 16'(16'h1000 + 256*j + r) : 16'h0;
      end
      ntests++; if (left_out !== d) begin nfail++; $display("FAIL forced_step%0d got=%h exp=%h", c, left_out, d); end
    end
    ntests++; if (nv != 19 || k_count !== 5'd16) begin nfail++; $display("FAIL forced_count valid=%0d k=%0d exp valid=19 k=16", nv, k_count); end
    @(negedge clk);
    ntests++; if ({tile_done, out_valid, in_ready, k_count} !== {3'b101, 5'd16}) begin nfail++; $display("FAIL forced_done got=%b exp=%b", {tile_done, out_valid, in_ready, k_count}, {3'b101, 5'd16}); end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    ntests++; if ({in_ready, k_count} !== {1'b0, 5'd1}) begin nfail++; $display("FAIL b2b_accept got=%b exp=%b", {in_ready, k_count}, {1'b0, 5'd1}); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      d = c < 4 ? x & (64'hFFFF << (16*c)) : 64'h0;
      ntests++; if (left_out !== d || out_valid !== (c < 4) || tile_done !== (c == 4)) begin nfail++; $display("FAIL b2b_cycle%0d got=%h v=%b td=%b exp=%h", c, left_out, out_valid, tile_done, d); end
    end
  endtask
  task automatic test_last_no_valid;
    @(negedge clk);
    in_last = 1'b1; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    ntests++; if ({in_ready, out_valid, k_count} !== {2'b10, 5'd1}) begin nfail++; $display("FAIL last_no_valid got=%b exp=%b", {in_ready, out_valid, k_count}, {2'b10, 5'd1}); end
    in_last = 1'b0;
  endtask
`ifdef FEEDER_STALL_EN
  task automatic test_stall;
    logic [R*W-1:0] exp [6] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0002_0005, 64'h0000_0003_0006_0009,
                                64'h0004_0007_000A_0000, 64'h0008_000B_0000_0000, 64'h000C_0000_0000_0000};
    int nv = 0;
    send(64'h0004_0003_0002_0001, 1'b0);
    send(64'h0008_0007_0006_0005, 1'b0);
    send(64'h000C_000B_000A_0009, 1'b1);
    @(negedge clk);
    nv += int'(out_valid);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      ntests++; if ({out_valid, mac_en} !== 2'b00 || left_out !== exp[0]) begin nfail++; $display("FAIL stall_hold%0d got=%b lo=%h", c, {out_valid, mac_en}, left_out); end
      @(negedge clk);
    end
    stall = 1'b0;
    for (int c = 1; c < 6; c++) begin
      @(negedge clk);
      nv += int'(out_valid);
      ntests++; if (left_out !== exp[c]) begin nfail++; $display("FAIL stall_step%0d got=%h exp=%h", c, left_out, exp[c]); end
    end
    @(negedge clk);
    ntests++; if (nv != 6 || tile_done !== 1'b1) begin nfail++; $display("FAIL stall_total valid=%0d td=%b exp 6/1", nv, tile_done); end
  endtask
`endif
  initial begin
    test_reset;
    test_reset_mid;
    test_basic;
    test_k1;
    test_back_to_back;
    test_last_no_valid;
`ifdef FEEDER_STALL_EN
    test_stall;
`endif
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
